// File: rtl/ppi_bus_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ppi_ctrl_pkg
// Brief   : Shared state encoding and 8255 register constants for the
//           PPI bus sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package ppi_ctrl_pkg;

    typedef enum logic [2:0] {
        P_RST       = 3'd0,
        INIT_SETUP  = 3'd1,
        INIT_STROBE = 3'd2,
        INIT_HOLD   = 3'd3,
        IDLE        = 3'd4,
        SETUP       = 3'd5,
        STROBE      = 3'd6,
        HOLD        = 3'd7
    } seq_state_t;

    localparam logic [1:0] PA   = 2'd0;
    localparam logic [1:0] PB   = 2'd1;
    localparam logic [1:0] PC   = 2'd2;
    localparam logic [1:0] CTRL = 2'd3;

    // Control word the 8255 assumes after its own reset
    localparam logic [7:0] CTRL_RST_WORD = 8'h9B;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppi_bus_sequencer_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ppi_rr_arbiter
// Brief   : Two-way round-robin grant; last-served pointer moves on ACK.
// Rev     : 1.0  initial release
// ============================================================================
module ppi_rr_arbiter (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] REQ,
    input  logic [1:0] ACK,
    output logic       GNT_VALID,
    output logic       GNT_IDX
);

    logic r_last;

    // Pointer starts at 1 so requester 0 wins the first tie
    always_ff @(posedge CLK) begin
        if (RESET)       r_last <= 1'b1;
        else if (ACK[0]) r_last <= 1'b0;
        else if (ACK[1]) r_last <= 1'b1;
    end

    always_comb begin
        GNT_VALID = |REQ;
        GNT_IDX   = 1'b0;
        case (REQ)
            2'b01:   GNT_IDX = 1'b0;
            2'b10:   GNT_IDX = 1'b1;
            2'b11:   GNT_IDX = ~r_last;
            default: GNT_IDX = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ppi_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ppi_bus_sequencer
// Brief   : Clocked 8255 PPI bus master with two-way round-robin sharing,
//           power-up PPI reset pulse and init control-word write.
// Rev     : 1.0  initial release
// ============================================================================
module ppi_bus_sequencer
    import ppi_ctrl_pkg::*;
#(
    parameter int          SETUP_CYC  = 1,
    parameter int          STROBE_CYC = 2,
    parameter int          HOLD_CYC   = 1,
    parameter int          RST_CYC    = 4,
    parameter logic [7:0]  INIT_CTRL  = 8'h80
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] REQ,
    input  logic [1:0] WE,
    input  logic [1:0] ADDR0,
    input  logic [1:0] ADDR1,
    input  logic [7:0] WDATA0,
    input  logic [7:0] WDATA1,
    output logic [1:0] ACK,
    output logic [7:0] RDATA,
    output logic       BUSY,
    output logic [7:0] CTRL_SHADOW,
    output logic [1:0] PPI_A,
    output logic       PPI_CS_N,
    output logic       PPI_RD_N,
    output logic       PPI_WR_N,
    output logic       PPI_RESET,
    output logic [7:0] PPI_D_OUT,
    output logic       PPI_D_OE,
    input  logic [7:0] PPI_D_IN
);

    localparam int c_MAX_CYC = max_of4(SETUP_CYC, STROBE_CYC, HOLD_CYC, RST_CYC);
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_SETUP_LD  = c_CNT_W'(SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_STROBE_LD = c_CNT_W'(STROBE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD   = c_CNT_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_RST_LD    = c_CNT_W'(RST_CYC - 1);

    seq_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_we;
    logic               r_gnt;
    logic               w_gnt_valid;
    logic               w_gnt_idx;
    logic [1:0]         w_ack_vec;

    assign w_ack_vec = r_gnt ? 2'b10 : 2'b01;

    ppi_rr_arbiter u_arb (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ       (REQ),
        .ACK       (ACK),
        .GNT_VALID (w_gnt_valid),
        .GNT_IDX   (w_gnt_idx)
    );

    // Each phase loads r_cnt with its length minus one and leaves at zero
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= P_RST;
            r_cnt       <= c_RST_LD;
            r_we        <= 1'b0;
            r_gnt       <= 1'b0;
            ACK         <= 2'b00;
            RDATA       <= 8'h00;
            BUSY        <= 1'b1;
            CTRL_SHADOW <= CTRL_RST_WORD;
            PPI_A       <= 2'd0;
            PPI_CS_N    <= 1'b1;
            PPI_RD_N    <= 1'b1;
            PPI_WR_N    <= 1'b1;
            PPI_RESET   <= 1'b1;
            PPI_D_OUT   <= 8'h00;
            PPI_D_OE    <= 1'b0;
        end else begin
            ACK <= 2'b00;
            case (r_state)
                P_RST: begin
                    if (r_cnt == '0) begin
                        r_state   <= INIT_SETUP;
                        r_cnt     <= c_SETUP_LD;
                        r_we      <= 1'b1;
                        PPI_RESET <= 1'b0;
                        PPI_CS_N  <= 1'b0;
                        PPI_A     <= CTRL;
                        PPI_D_OUT <= INIT_CTRL;
                        PPI_D_OE  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_state   <= SETUP;
                        r_cnt     <= c_SETUP_LD;
                        r_gnt     <= w_gnt_idx;
                        r_we      <= WE[w_gnt_idx];
                        BUSY      <= 1'b1;
                        PPI_CS_N  <= 1'b0;
                        PPI_A     <= w_gnt_idx ? ADDR1 : ADDR0;
                        PPI_D_OUT <= w_gnt_idx ? WDATA1 : WDATA0;
                        PPI_D_OE  <= WE[w_gnt_idx];
                    end
                end
                INIT_SETUP, SETUP: begin
                    if (r_cnt == '0) begin
                        r_state  <= (r_state == INIT_SETUP) ? INIT_STROBE : STROBE;
                        r_cnt    <= c_STROBE_LD;
                        PPI_WR_N <= ~r_we;
                        PPI_RD_N <= r_we;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                INIT_STROBE, STROBE: begin
                    if (r_cnt == '0) begin
                        r_state  <= (r_state == INIT_STROBE) ? INIT_HOLD : HOLD;
                        r_cnt    <= c_HOLD_LD;
                        PPI_WR_N <= 1'b1;
                        PPI_RD_N <= 1'b1;
                        if (r_state == STROBE) begin
                            if (!r_we) RDATA <= PPI_D_IN;
                            if (HOLD_CYC == 1) ACK <= w_ack_vec;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                INIT_HOLD, HOLD: begin
                    if (r_cnt == '0) begin
                        r_state  <= IDLE;
                        BUSY     <= 1'b0;
                        PPI_CS_N <= 1'b1;
                        PPI_D_OE <= 1'b0;
                        if (r_state == INIT_HOLD)
                            CTRL_SHADOW <= INIT_CTRL;
                        else if (r_we && PPI_A == CTRL && PPI_D_OUT[7])
                            CTRL_SHADOW <= PPI_D_OUT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        // ACK lands on the final HOLD cycle
                        if (r_state == HOLD && r_cnt == c_CNT_W'(1)) ACK <= w_ack_vec;
                    end
                end
                default: begin
                    r_state <= P_RST;
                    r_cnt   <= c_RST_LD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ppi_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ppi_bus_sequencer
// Brief   : Randomized self-checking bench for ppi_bus_sequencer against a
//           transaction-level timing model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ppi_bus_sequencer;
    import ppi_ctrl_pkg::*;

    localparam int S  = 1;
    localparam int ST = 2;
    localparam int H  = 1;
    localparam int R  = 4;
    localparam int L  = S + ST + H;
    localparam logic [7:0] INIT_WORD = 8'h80;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [1:0] REQ = 2'b00, WE = 2'b00, ADDR0 = 2'd0, ADDR1 = 2'd0;
    logic [7:0] WDATA0 = 8'h00, WDATA1 = 8'h00, PPI_D_IN = 8'h00;
    logic [1:0] ACK, PPI_A;
    logic [7:0] RDATA, CTRL_SHADOW, PPI_D_OUT;
    logic       BUSY, PPI_CS_N, PPI_RD_N, PPI_WR_N, PPI_RESET, PPI_D_OE;

    always #5 CLK = ~CLK;

    ppi_bus_sequencer #(
        .SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H), .RST_CYC(R), .INIT_CTRL(INIT_WORD)
    ) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .WE(WE), .ADDR0(ADDR0), .ADDR1(ADDR1),
        .WDATA0(WDATA0), .WDATA1(WDATA1), .ACK(ACK), .RDATA(RDATA), .BUSY(BUSY),
        .CTRL_SHADOW(CTRL_SHADOW), .PPI_A(PPI_A), .PPI_CS_N(PPI_CS_N),
        .PPI_RD_N(PPI_RD_N), .PPI_WR_N(PPI_WR_N), .PPI_RESET(PPI_RESET),
        .PPI_D_OUT(PPI_D_OUT), .PPI_D_OE(PPI_D_OE), .PPI_D_IN(PPI_D_IN)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic       last_m;
    logic [7:0] shadow_m;
    logic [7:0] rdata_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at the negedge of the first cycle after a reset edge
    task automatic release_and_init();
        logic in_cyc;
        REQ = 2'b00;
        for (int j = 0; j <= R + L; j++) begin
            if (j > 0) @(negedge CLK);
            in_cyc = (j >= R) && (j < R + L);
            chk("init_ppi_reset", PPI_RESET, j < R);
            chk("init_cs_n", PPI_CS_N, !in_cyc);
            chk("init_wr_n", PPI_WR_N, !((j >= R + S) && (j < R + S + ST)));
            chk("init_rd_n", PPI_RD_N, 1);
            chk("init_d_oe", PPI_D_OE, in_cyc);
            if (in_cyc) begin
                chk("init_a", PPI_A, CTRL);
                chk("init_d_out", PPI_D_OUT, INIT_WORD);
            end
            chk("init_busy", BUSY, j < R + L);
            chk("init_shadow", CTRL_SHADOW, (j < R + L) ? 8'h9B : INIT_WORD);
            chk("init_ack", ACK, 0);
            chk("init_rdata", RDATA, 0);
            if (j == 0) RESET = 1'b0;
        end
        last_m   = 1'b1;
        shadow_m = INIT_WORD;
        rdata_m  = 8'h00;
    endtask

    task automatic idle_cycles(input int n);
        REQ = 2'b00;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk("idle_busy", BUSY, 0);
            chk("idle_cs_n", PPI_CS_N, 1);
            chk("idle_ack", ACK, 0);
        end
    endtask

    // Called at a negedge of a cycle in which the sequencer is idle
    task automatic run_txn(input logic [1:0] req, input logic [1:0] we,
                           input logic [1:0] a0, input logic [1:0] a1,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] din, input bit drop);
        int         w;
        logic       we_w, in_cyc, strobe;
        logic [1:0] a_w;
        logic [7:0] d_w, sh_next;
        w = (req == 2'b11) ? (last_m ? 0 : 1) : (req[1] ? 1 : 0);
        we_w = we[w];
        a_w  = (w == 1) ? a1 : a0;
        d_w  = (w == 1) ? d1 : d0;
        sh_next = (we_w && a_w == CTRL && d_w[7]) ? d_w : shadow_m;
        REQ = req; WE = we; ADDR0 = a0; ADDR1 = a1; WDATA0 = d0; WDATA1 = d1;
        PPI_D_IN = 8'($urandom);
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge CLK);
            in_cyc = (k <= L);
            strobe = (k > S) && (k <= S + ST);
            if (k == S + ST + 1 && !we_w) rdata_m = din;
            chk("cs_n", PPI_CS_N, !in_cyc);
            chk("rd_n", PPI_RD_N, !(strobe && !we_w));
            chk("wr_n", PPI_WR_N, !(strobe && we_w));
            chk("d_oe", PPI_D_OE, in_cyc && we_w);
            if (in_cyc) chk("ppi_a", PPI_A, a_w);
            if (in_cyc && we_w) chk("d_out", PPI_D_OUT, d_w);
            chk("ack", ACK, (k == L) ? (32'd1 << w) : 32'd0);
            chk("busy", BUSY, in_cyc);
            chk("rdata", RDATA, rdata_m);
            chk("shadow", CTRL_SHADOW, (k <= L) ? shadow_m : sh_next);
            chk("ppi_reset", PPI_RESET, 0);
            if (k == 1) begin
                WE = 2'($urandom); ADDR0 = 2'($urandom); ADDR1 = 2'($urandom);
                WDATA0 = 8'($urandom); WDATA1 = 8'($urandom);
                if (drop) REQ[w] = 1'b0;
            end
            PPI_D_IN = (k == S + ST) ? din : 8'($urandom);
        end
        last_m   = w[0];
        shadow_m = sh_next;
    endtask

    initial begin
        logic [1:0] rq;
        @(negedge CLK);
        chk("rst_ack", ACK, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_busy", BUSY, 1);
        chk("rst_shadow", CTRL_SHADOW, 8'h9B);
        chk("rst_cs_rd_wr", {PPI_CS_N, PPI_RD_N, PPI_WR_N}, 3'b111);
        chk("rst_d_oe", PPI_D_OE, 0);
        chk("rst_a", PPI_A, 0);
        chk("rst_d_out", PPI_D_OUT, 0);
        chk("rst_ppi_reset", PPI_RESET, 1);
        @(negedge CLK);
        release_and_init();

        run_txn(2'b01, 2'b01, PA, PA, 8'h5A, 8'h00, 8'h00, 1'b0);
        idle_cycles(1);
        run_txn(2'b10, 2'b00, PA, PB, 8'h00, 8'h00, 8'hC3, 1'b0);
        idle_cycles(1);
        for (int i = 0; i < 4; i++)
            run_txn(2'b11, 2'($urandom), 2'($urandom), 2'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        idle_cycles(1);
        run_txn(2'b01, 2'b01, CTRL, PA, 8'h07, 8'h00, 8'h00, 1'b0);
        run_txn(2'b10, 2'b10, PA, CTRL, 8'h00, 8'h9B, 8'h00, 1'b0);
        idle_cycles(2);

        for (int i = 0; i < 40; i++) begin
            rq = 2'($urandom_range(1, 3));
            run_txn(rq, 2'($urandom), 2'($urandom), 2'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(1, 2));
        end

        // Reset while the write strobe is active
        idle_cycles(1);
        REQ = 2'b01; WE = 2'b01; ADDR0 = PB; WDATA0 = 8'h3C;
        @(negedge CLK);
        @(negedge CLK);
        chk("mid_wr_n_low", PPI_WR_N, 0);
        RESET = 1'b1;
        @(negedge CLK);
        chk("mid_cs_n", PPI_CS_N, 1);
        chk("mid_rd_wr", {PPI_RD_N, PPI_WR_N}, 2'b11);
        chk("mid_d_oe", PPI_D_OE, 0);
        chk("mid_ack", ACK, 0);
        chk("mid_ppi_reset", PPI_RESET, 1);
        chk("mid_busy", BUSY, 1);
        release_and_init();
        for (int i = 0; i < 2; i++)
            run_txn(2'b11, 2'b00, PC, PA, 8'h00, 8'h00, 8'($urandom), 1'b0);
        idle_cycles(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
